// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT over a shared sample RAM.
// Walks stages and butterflies, driving RAM, twiddle ROM and butterfly-unit strobes.
module fft_stage_sequencer #(
  parameter int MAX_LOG2N = 11,
  parameter int BFLY_LAT  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_DATA_LOADED,
  input  logic [MAX_LOG2N:0]   i_SAMPLES_NUMBER,
  output logic [MAX_LOG2N:0]   o_RAM_ADDR,
  output logic                 o_RAM_RD,
  output logic                 o_RAM_WR,
  output logic                 o_WR_SEL,
  output logic                 o_BFLY_LOAD_A,
  output logic                 o_BFLY_LOAD_B,
  output logic                 o_BFLY_START,
  output logic [MAX_LOG2N-1:0] o_TWIDDLE_ADDR,
  output logic [3:0]           o_STAGE,
  output logic                 o_BUSY,
  output logic                 o_CALC_END,
  output logic                 o_ERR
);

  localparam int AW = MAX_LOG2N + 1;
  localparam int TW = MAX_LOG2N;
  localparam int CW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_LD_B, S_WAIT, S_WR_A, S_WR_B, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      s_q, l_q;
  logic [TW-1:0]   k_q;
  logic [AW-1:0]   n_q;
  logic [CW-1:0]   cnt_q;
  logic            calc_end_q, err_q;

  logic            n_valid, start_ok, start_bad, last_k, last_s;
  logic [AW-1:0]   k_ext, half, j, a_addr, b_addr;
  logic [TW-1:0]   tw;

  function automatic logic [3:0] log2_of(input logic [AW-1:0] n);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < AW; i++)
      if (n[i]) r = 4'(i);
    return r;
  endfunction

  // A power of two above 1 that fits in AW bits is automatically <= 2^MAX_LOG2N.
  assign n_valid   = (i_SAMPLES_NUMBER > AW'(1)) &&
                     ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - AW'(1))) == '0);
  assign start_ok  = (state_q == S_IDLE) && i_DATA_LOADED && n_valid;
  assign start_bad = (state_q == S_IDLE) && i_DATA_LOADED && !n_valid;

  assign k_ext  = {1'b0, k_q};
  assign half   = AW'(1) << s_q;
  assign j      = k_ext & (half - AW'(1));
  assign a_addr = ((k_ext >> s_q) << (s_q + 4'd1)) | j;
  assign b_addr = a_addr + half;
  assign tw     = TW'(j << (l_q - 4'd1 - s_q));
  assign last_k = (k_ext == ((n_q >> 1) - AW'(1)));
  assign last_s = (s_q == (l_q - 4'd1));

  assign o_CALC_END = calc_end_q;
  assign o_ERR      = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      s_q        <= '0;
      l_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      calc_end_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      case (state_q)
        S_IDLE: if (start_ok) begin
          n_q        <= i_SAMPLES_NUMBER;
          l_q        <= log2_of(i_SAMPLES_NUMBER);
          s_q        <= '0;
          k_q        <= '0;
          calc_end_q <= 1'b0;
        end
        S_LD_B: cnt_q <= CW'(BFLY_LAT - 1);
        S_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        S_WR_B: begin
          if (!last_k) k_q <= k_q + TW'(1);
          else if (!last_s) begin
            s_q <= s_q + 4'd1;
            k_q <= '0;
          end else calc_end_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    o_RAM_ADDR     = '0;
    o_RAM_RD       = 1'b0;
    o_RAM_WR       = 1'b0;
    o_WR_SEL       = 1'b0;
    o_BFLY_LOAD_A  = 1'b0;
    o_BFLY_LOAD_B  = 1'b0;
    o_BFLY_START   = 1'b0;
    o_TWIDDLE_ADDR = '0;
    o_STAGE        = '0;
    o_BUSY         = (state_q != S_IDLE);
    if (state_q != S_IDLE && state_q != S_DONE) begin
      o_TWIDDLE_ADDR = tw;
      o_STAGE        = s_q;
    end
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_RD_A;
      S_RD_A: begin
        state_d    = S_RD_B;
        o_RAM_ADDR = a_addr;
        o_RAM_RD   = 1'b1;
      end
      S_RD_B: begin
        state_d       = S_LD_B;
        o_RAM_ADDR    = b_addr;
        o_RAM_RD      = 1'b1;
        o_BFLY_LOAD_A = 1'b1;
      end
      S_LD_B: begin
        state_d       = S_WAIT;
        o_BFLY_LOAD_B = 1'b1;
        o_BFLY_START  = 1'b1;
      end
      S_WAIT: if (cnt_q == '0) state_d = S_WR_A;
      S_WR_A: begin
        state_d    = S_WR_B;
        o_RAM_ADDR = a_addr;
        o_RAM_WR   = 1'b1;
      end
      S_WR_B: begin
        state_d    = (last_k && last_s) ? S_DONE : S_RD_A;
        o_RAM_ADDR = b_addr;
        o_RAM_WR   = 1'b1;
        o_WR_SEL   = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
